// File: rtl/crc_check_scheduler.sv
// crc_check_scheduler: round-robin sharing of one serial CRC-32 checker among NUM_PORTS ingress ports.
// Optional per-port frame/error counters are enabled with `define CRC_STATS_EN.
module crc_check_scheduler #(
  parameter int NUM_PORTS       = 4,
  parameter int RESULT_LATENCY  = 34,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req,
  output logic [NUM_PORTS-1:0]           grant,
  input  logic [8*NUM_PORTS-1:0]         s_data,
  input  logic [NUM_PORTS-1:0]           s_valid,
  input  logic [NUM_PORTS-1:0]           s_last,
  output logic [NUM_PORTS-1:0]           s_ready,
  output logic                           crc_sof,
  output logic                           crc_eof,
  output logic                           crc_bit,
  input  logic                           crc_error,
  output logic                           res_valid,
  output logic [$clog2(NUM_PORTS)-1:0]   res_port,
  output logic                           res_error,
  output logic                           res_oversize,
  output logic [15:0]                    res_bytes,
  output logic                           busy
`ifdef CRC_STATS_EN
  ,
  input  logic [$clog2(NUM_PORTS)-1:0]   stat_sel,
  output logic [31:0]                    stat_frames,
  output logic [31:0]                    stat_errors
`endif
);
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DISCARD, WAIT, REPORT} state_t;
  state_t state;
  logic [PW-1:0] ptr, gi, sel;
  logic [7:0] sh, g_data;
  logic [2:0] bit_cnt;
  logic [15:0] byte_cnt, nxt_cnt, wait_cnt;
  logic last_q, ovf, g_valid, g_last, taking;
  assign g_data  = s_data[{gi, 3'b000} +: 8];
  assign g_valid = s_valid[gi];
  assign g_last  = s_last[gi];
  assign taking  = state == LOAD || state == DISCARD;
  assign s_ready = taking ? grant : '0;
  assign busy    = state != IDLE;
  assign crc_bit = sh[0];
  assign nxt_cnt = byte_cnt == 16'hFFFF ? byte_cnt : byte_cnt + 16'd1;
  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    int j;
    j = 0;
    sel = ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_PORTS;
      if (req[j]) sel = PW'(j);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      gi           <= '0;
      grant        <= '0;
      sh           <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
      last_q       <= 1'b0;
      ovf          <= 1'b0;
      crc_sof      <= 1'b0;
      crc_eof      <= 1'b0;
      res_valid    <= 1'b0;
      res_port     <= '0;
      res_error    <= 1'b0;
      res_oversize <= 1'b0;
      res_bytes    <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gi       <= sel;
          grant    <= NUM_PORTS'(1) << sel;
          byte_cnt <= '0;
          ovf      <= 1'b0;
          state    <= LOAD;
        end
        LOAD: if (g_valid) begin
          byte_cnt <= nxt_cnt;
          last_q   <= g_last;
          if (byte_cnt == 16'(MAX_FRAME_BYTES) && !g_last) begin
            ovf   <= 1'b1;
            state <= DISCARD;
          end else begin
            sh      <= g_data;
            bit_cnt <= '0;
            crc_sof <= byte_cnt == 16'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          crc_sof <= 1'b0;
          crc_eof <= bit_cnt == 3'd6 && last_q;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt != 3'd7) sh <= sh >> 1;
          if (bit_cnt == 3'd7) begin
            wait_cnt <= 16'd1;
            state    <= last_q ? WAIT : LOAD;
          end
        end
        // The flush eof cycle is the first WAIT cycle, hence wait_cnt starts at 0 here.
        DISCARD: if (g_valid) begin
          byte_cnt <= nxt_cnt;
          if (g_last) begin
            crc_eof  <= 1'b1;
            sh       <= '0;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          crc_eof <= 1'b0;
          if (wait_cnt == 16'(RESULT_LATENCY)) begin
            res_valid    <= 1'b1;
            res_port     <= gi;
            res_oversize <= ovf;
            res_error    <= crc_error | ovf;
            res_bytes    <= byte_cnt;
            state        <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        REPORT: begin
          res_valid <= 1'b0;
          grant     <= '0;
          ptr       <= gi == PW'(NUM_PORTS - 1) ? '0 : gi + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CRC_STATS_EN
  logic [31:0] frames [NUM_PORTS];
  logic [31:0] errors [NUM_PORTS];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        frames[i] <= '0;
        errors[i] <= '0;
      end
    end else if (state == REPORT) begin
      frames[gi] <= frames[gi] + 32'd1;
      if (res_error) errors[gi] <= errors[gi] + 32'd1;
    end
  end
  assign stat_frames = int'(stat_sel) < NUM_PORTS ? frames[stat_sel] : '0;
  assign stat_errors = int'(stat_sel) < NUM_PORTS ? errors[stat_sel] : '0;
`endif
endmodule

// File: tb/tb_crc_check_scheduler.sv
// tb_crc_check_scheduler: scoreboard bench; per-port byte sources, bit/strobe and result queues stamped with cycles.
module tb_crc_check_scheduler;
  localparam int N     = 4;
  localparam int LAT   = 34;
  localparam int MAXB  = 1522;
  localparam int DEPTH = 8192;
  typedef struct {int c; bit b; bit s; bit e;} bit_t;
  typedef struct {int c; int port; int bytes; bit ovf; bit err;} res_t;
  typedef struct {int port; int len; bit inj; bit stall; int exp_bytes; bit exp_ovf; bit exp_err;} vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0, s_valid = '0, s_last = '0, grant, s_ready;
  logic [8*N-1:0] s_data = '0;
  logic crc_sof, crc_eof, crc_bit, crc_error = 1'b0;
  logic res_valid, res_error, res_oversize, busy;
  logic [1:0] res_port;
  logic [15:0] res_bytes;
`ifdef CRC_STATS_EN
  logic [1:0] stat_sel = '0;
  logic [31:0] stat_frames, stat_errors;
`endif

  crc_check_scheduler #(.NUM_PORTS(N), .RESULT_LATENCY(LAT), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .crc_sof(crc_sof), .crc_eof(crc_eof), .crc_bit(crc_bit), .crc_error(crc_error),
    .res_valid(res_valid), .res_port(res_port), .res_error(res_error),
    .res_oversize(res_oversize), .res_bytes(res_bytes), .busy(busy)
`ifdef CRC_STATS_EN
    , .stat_sel(stat_sel), .stat_frames(stat_frames), .stat_errors(stat_errors)
`endif
  );

  always #5 clk = ~clk;

  bit [9:0] mem [N][DEPTH];
  int head [N], tail [N], cnt [N], stall [N], stall_after [N], sf [N], se [N];
  bit disc [N], acc [N];
  bit_t bq [$];
  res_t rq [$];
  int glog [$];
  int checks = 0, fails = 0, cyc = 0, err_cyc = -1;
  int sof_c = 0, eof_c = 0, res_c = 0, gnt_c = 0, n_res = 0, cap_i = 8;
  logic [7:0] cap = '0;
  logic [N-1:0] prev_grant = '0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic flag(string name);
    checks++;
    fails++;
    $display("FAIL %s at cycle %0d: event occurred, expected none", name, cyc);
  endtask

  task automatic push_byte(int p, logic [7:0] d, bit l, bit inj);
    mem[p][tail[p] % DEPTH] = {inj, l, d};
    tail[p]++;
  endtask

  task automatic push_frame(int p, int len, bit inj, int seed);
    for (int i = 0; i < len; i++) push_byte(p, 8'((i * 37 + seed) & 255), i == len - 1, inj && i == len - 1);
  endtask

  // Model of one accepted byte: schedule its serialized bits, strobes and (on last) the result.
  task automatic consume(int p);
    bit [9:0] e;
    int e_c;
    e = mem[p][head[p] % DEPTH];
    head[p]++;
    if (!disc[p] && cnt[p] == MAXB && !e[8]) disc[p] = 1'b1;
    if (!disc[p]) begin
      for (int k = 0; k < 8; k++) bq.push_back(bit_t'{cyc + k, e[k], cnt[p] == 0 && k == 0, e[8] && k == 7});
    end else if (e[8]) begin
      bq.push_back(bit_t'{cyc, 1'b0, 1'b0, 1'b1});
    end
    cnt[p]++;
    if (stall_after[p] == cnt[p]) stall[p] = 8 + 5;
    if (e[8]) begin
      e_c = disc[p] ? cyc : cyc + 7;
      rq.push_back(res_t'{e_c + LAT + 1, p, cnt[p], disc[p], e[9] | disc[p]});
      if (e[9]) err_cyc = e_c + LAT;
      cnt[p] = 0;
      disc[p] = 1'b0;
      stall_after[p] = -1;
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (head[p] != tail[p]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit [9:0] e;
    bit exp_s, exp_e;
    bit_t b;
    res_t r;
    cyc++;
    for (int p = 0; p < N; p++) if (acc[p]) consume(p);
    for (int p = 0; p < N; p++) begin
      e = mem[p][head[p] % DEPTH];
      req[p] = head[p] != tail[p];
      if (stall[p] > 0) begin
        stall[p]--;
        s_valid[p] = 1'b0;
      end else begin
        s_valid[p] = head[p] != tail[p];
      end
      s_data[8*p +: 8] = e[7:0];
      s_last[p] = e[8];
      acc[p] = s_valid[p] && s_ready[p];
    end
    crc_error = cyc == err_cyc;
    exp_s = 1'b0;
    exp_e = 1'b0;
    while (bq.size() > 0 && bq[0].c < cyc) begin
      void'(bq.pop_front());
      flag("bit_skipped");
    end
    if (bq.size() > 0 && bq[0].c == cyc) begin
      b = bq.pop_front();
      check("crc_bit", crc_bit, b.b);
      exp_s = b.s;
      exp_e = b.e;
    end
    if (crc_sof || exp_s) check("crc_sof", crc_sof, exp_s);
    if (crc_eof || exp_e) check("crc_eof", crc_eof, exp_e);
    if (crc_sof) begin
      sof_c = cyc;
      cap_i = 0;
    end
    if (cap_i < 8) begin
      cap[cap_i] = crc_bit;
      cap_i++;
    end
    if (crc_eof) eof_c = cyc;
    if (grant != '0) check("grant_onehot", $onehot(grant), 1);
    if (grant != '0 && prev_grant == '0) begin
      glog.push_back($clog2(grant));
      gnt_c = cyc;
    end
    prev_grant = grant;
    if (s_ready != '0) check("s_ready_vs_grant", s_ready, grant);
    if (res_valid) begin
      res_c = cyc;
      n_res++;
      if (rq.size() == 0) begin
        flag("res_spurious");
      end else begin
        r = rq.pop_front();
        check("res_cycle", cyc, r.c);
        check("res_port", res_port, r.port);
        check("res_bytes", res_bytes, r.bytes);
        check("res_oversize", res_oversize, r.ovf);
        check("res_error", res_error, r.err);
        sf[r.port]++;
        se[r.port] += int'(r.err);
      end
    end else if (rq.size() > 0 && cyc > rq[0].c) begin
      void'(rq.pop_front());
      flag("res_missing");
    end
  end

  task automatic wait_idle(int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      done = rq.size() == 0 && !busy && all_empty();
    end
    check("idle_reached", done, 1);
  endtask

  initial begin
    vec_t vt [6];
    int n0;
    for (int p = 0; p < N; p++) stall_after[p] = -1;
    vt[0] = '{2, 16, 1'b1, 1'b0, 16, 1'b0, 1'b1};
    vt[1] = '{3, 5, 1'b0, 1'b0, 5, 1'b0, 1'b0};
    vt[2] = '{1, 1530, 1'b0, 1'b0, 1530, 1'b1, 1'b1};
    vt[3] = '{0, 20, 1'b0, 1'b1, 20, 1'b0, 1'b0};
    vt[4] = '{1, 1522, 1'b0, 1'b0, 1522, 1'b0, 1'b0};
    vt[5] = '{2, 1, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_sof", crc_sof, 0);
    check("rst_eof", crc_eof, 0);
    check("rst_bit", crc_bit, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_bytes", res_bytes, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // All four ports requesting, port 0 with a second frame queued behind the first.
    for (int p = 0; p < N; p++) push_frame(p, 64, 1'b0, p * 3 + 1);
    push_frame(0, 64, 1'b0, 99);
    wait_idle(4000);
    check("rr_grants", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) check("rr_order", glog[i], i % 4);

    push_byte(0, 8'hA5, 1'b1, 1'b0);
    wait_idle(200);
    check("a5_bits", cap, 8'hA5);
    check("a5_sof_to_eof", eof_c - sof_c, 7);
    check("a5_eof_to_res", res_c - eof_c, LAT + 1);
    check("a5_grant_to_res", res_c - gnt_c, 43);
    check("a5_port", res_port, 0);
    check("a5_bytes", res_bytes, 1);

    foreach (vt[i]) begin
      n0 = n_res;
      if (vt[i].stall) stall_after[vt[i].port] = 3;
      push_frame(vt[i].port, vt[i].len, vt[i].inj, i * 17 + 3);
      wait_idle(vt[i].len * 12 + 200);
      check("vec_results", n_res - n0, 1);
      check("vec_port", res_port, vt[i].port);
      check("vec_bytes", res_bytes, vt[i].exp_bytes);
      check("vec_oversize", res_oversize, vt[i].exp_ovf);
      check("vec_error", res_error, vt[i].exp_err);
`ifdef CRC_STATS_EN
      stat_sel = 2'(vt[i].port);
      #1;
      check("stat_frames", stat_frames, sf[vt[i].port]);
      check("stat_errors", stat_errors, se[vt[i].port]);
`endif
    end

    // Reset in the middle of serializing a port-3 frame.
    push_frame(3, 10, 1'b0, 7);
    for (int k = 0; k < 100 && !crc_sof; k++) begin
      @(negedge clk);
      #1;
    end
    check("mid_sof_seen", crc_sof, 1);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_sof", crc_sof, 0);
    check("mid_rst_eof", crc_eof, 0);
    check("mid_rst_bit", crc_bit, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    for (int p = 0; p < N; p++) begin
      head[p] = tail[p];
      cnt[p] = 0;
      disc[p] = 1'b0;
      acc[p] = 1'b0;
      stall[p] = 0;
      sf[p] = 0;
      se[p] = 0;
    end
    bq.delete();
    rq.delete();
    err_cyc = -1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    glog.delete();
    n0 = n_res;
    push_frame(3, 4, 1'b0, 11);
    wait_idle(300);
    check("post_rst_grant", glog.size() > 0 ? glog[0] : -1, 3);
    check("post_rst_results", n_res - n0, 1);
    check("post_rst_port", res_port, 3);
    check("post_rst_bytes", res_bytes, 4);
    check("post_rst_error", res_error, 0);
`ifdef CRC_STATS_EN
    stat_sel = 2'd3;
    #1;
    check("post_rst_stat_frames", stat_frames, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog at cycle %0d: simulation did not complete, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
